// File: rtl/ccip_mmio_rx_assembler.sv
// ccip_mmio_rx_assembler: decodes CCI-P MMIO writes into per-flow line windows and
// assembles MMIO words into full cache lines queued in a first-word-fall-through FIFO.
module ccip_mmio_rx_assembler #(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 2,
    parameter int MMIO_WORD_BITS    = 64,
    parameter int CL_BITS           = 512,
    parameter int LFIFO_DEPTH       = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [LMAX_NUM_OF_FLOWS:0]   number_of_flows,
    input  logic [15:0]                  tx_base_addr,
    input  logic                         mmio_wr_valid,
    input  logic [15:0]                  mmio_wr_addr,
    input  logic [MMIO_WORD_BITS-1:0]    mmio_wr_data,
    output logic [CL_BITS-1:0]           rpc_out,
    output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
    output logic                         rpc_out_valid,
    input  logic                         rpc_out_ready,
    output logic [LFIFO_DEPTH:0]         fifo_occupancy,
    output logic [31:0]                  pdrop_count,
    output logic                         error
);

    localparam int LF  = LMAX_NUM_OF_FLOWS;
    localparam int NF  = 1 << LF;
    localparam int WPD = MMIO_WORD_BITS / 32;
    localparam int WSH = (WPD > 1) ? $clog2(WPD) : 0;
    localparam int NW  = CL_BITS / MMIO_WORD_BITS;
    localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int FD  = 1 << LFIFO_DEPTH;

    logic [16:0] off;
    logic [4:0]  word_full;
    logic        in_range, aligned, word_ok, accept, misaligned;

    logic                      s1_valid_q;
    logic [LF-1:0]             s1_flow_q;
    logic [WW-1:0]             s1_word_q;
    logic [MMIO_WORD_BITS-1:0] s1_data_q;

    logic [NF-1:0][NW-1:0] mask_q;
    logic [CL_BITS-1:0]    stage_q [NF];
    logic [NW-1:0]         mask_upd;
    logic [CL_BITS-1:0]    line_upd;
    logic                  commit;

    logic [CL_BITS-1:0]     mem_line_q [FD];
    logic [LF-1:0]          mem_flow_q [FD];
    logic [LFIFO_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
    logic [LFIFO_DEPTH:0]   mem_cnt_q;
    logic                   head_v_q;
    logic [CL_BITS-1:0]     head_line_q;
    logic [LF-1:0]          head_flow_q;
    logic [31:0]            pdrop_q;
    logic                   error_q;
    logic                   pop, load, full, push, drop;

    logic unused_nic;
    assign unused_nic = ^NIC_ID;

    // 17-bit difference so that writes below the base are caught by the sign bit
    assign off        = {1'b0, mmio_wr_addr} - {1'b0, tx_base_addr};
    assign in_range   = !off[16] && (off < 17'({number_of_flows, 4'b0000}));
    assign word_full  = {1'b0, off[3:0]} >> WSH;
    assign word_ok    = int'(word_full) < NW;
    assign aligned    = (off[3:0] & 4'(WPD - 1)) == 4'b0000;
    assign accept     = start && mmio_wr_valid && in_range && aligned && word_ok;
    assign misaligned = start && mmio_wr_valid && in_range && !aligned;

    always_comb begin
        mask_upd = mask_q[s1_flow_q] | (NW'(1) << s1_word_q);
        line_upd = stage_q[s1_flow_q];
        line_upd[s1_word_q*MMIO_WORD_BITS +: MMIO_WORD_BITS] = s1_data_q;
        commit   = s1_valid_q && start && (&mask_upd);
    end

    // Output head is a separate register, so a pushed line becomes visible one edge later
    assign fifo_occupancy = mem_cnt_q + (LFIFO_DEPTH+1)'(head_v_q);
    assign pop  = head_v_q && rpc_out_ready;
    assign load = (mem_cnt_q != '0) && (!head_v_q || pop);
    assign full = fifo_occupancy == (LFIFO_DEPTH+1)'(FD);
    assign push = commit && (!full || pop);
    assign drop = commit && !push;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            mask_q      <= '0;
            error_q     <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            head_v_q    <= 1'b0;
            head_line_q <= '0;
            head_flow_q <= '0;
            pdrop_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (misaligned) error_q <= 1'b1;
            if (!start) mask_q <= '0;
            else if (s1_valid_q) mask_q[s1_flow_q] <= commit ? '0 : mask_upd;
            if (push) wr_ptr_q <= wr_ptr_q + LFIFO_DEPTH'(1);
            if (load) begin
                rd_ptr_q    <= rd_ptr_q + LFIFO_DEPTH'(1);
                head_line_q <= mem_line_q[rd_ptr_q];
                head_flow_q <= mem_flow_q[rd_ptr_q];
            end
            head_v_q  <= load || (head_v_q && !pop);
            mem_cnt_q <= mem_cnt_q + (LFIFO_DEPTH+1)'(push) - (LFIFO_DEPTH+1)'(load);
            if (drop && pdrop_q != '1) pdrop_q <= pdrop_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        s1_flow_q <= off[LF+3:4];
        s1_word_q <= WW'(word_full);
        s1_data_q <= mmio_wr_data;
        if (s1_valid_q && start) stage_q[s1_flow_q] <= line_upd;
        if (push) begin
            mem_line_q[wr_ptr_q] <= line_upd;
            mem_flow_q[wr_ptr_q] <= s1_flow_q;
        end
    end

    assign rpc_out         = head_line_q;
    assign rpc_flow_id_out = head_flow_q;
    assign rpc_out_valid   = head_v_q;
    assign pdrop_count     = pdrop_q;
    assign error           = error_q;

endmodule

// File: tb/tb_ccip_mmio_rx_assembler.sv
// Randomised and directed bench for ccip_mmio_rx_assembler against a queue-based line model.
module tb_ccip_mmio_rx_assembler;

    localparam int FD = 2;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   number_of_flows;
    logic [15:0]  tx_base_addr, mmio_wr_addr;
    logic         mmio_wr_valid;
    logic [63:0]  mmio_wr_data;
    logic [511:0] rpc_out;
    logic [1:0]   rpc_flow_id_out;
    logic         rpc_out_valid, rpc_out_ready;
    logic [1:0]   fifo_occupancy;
    logic [31:0]  pdrop_count;
    logic         error;

    always #5 clk = ~clk;

    ccip_mmio_rx_assembler #(
        .NIC_ID(0), .LMAX_NUM_OF_FLOWS(2), .MMIO_WORD_BITS(64), .CL_BITS(512), .LFIFO_DEPTH(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .number_of_flows(number_of_flows),
        .tx_base_addr(tx_base_addr), .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr),
        .mmio_wr_data(mmio_wr_data), .rpc_out(rpc_out), .rpc_flow_id_out(rpc_flow_id_out),
        .rpc_out_valid(rpc_out_valid), .rpc_out_ready(rpc_out_ready),
        .fifo_occupancy(fifo_occupancy), .pdrop_count(pdrop_count), .error(error)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Model: per-flow word sets, a queue of committed lines stamped with their push edge.
    typedef struct { logic [1:0] flow; logic [511:0] line; int t; } ent_t;
    typedef struct { int flow; logic [63:0] w0; } seen_t;
    ent_t         q[$];
    seen_t        seen[$];
    logic [7:0]   m_mask [4];
    logic [511:0] m_stage [4];
    bit           p_v;
    int           p_flow, p_word;
    logic [63:0]  p_data;
    int           edge_n = 0;
    logic [31:0]  m_drop;
    bit           m_err;

    always @(posedge clk) begin
        bit   pop, commit, was_full;
        int   off;
        ent_t e;
        edge_n++;
        if (reset) begin
            for (int f = 0; f < 4; f++) m_mask[f] = '0;
            q.delete();
            p_v = 1'b0;
            m_drop = '0;
            m_err = 1'b0;
        end else begin
            pop = rpc_out_ready && q.size() > 0 && q[0].t + 1 <= edge_n - 1;
            was_full = q.size() == FD;
            commit = 1'b0;
            if (!start) begin
                for (int f = 0; f < 4; f++) m_mask[f] = '0;
            end else if (p_v) begin
                m_stage[p_flow][p_word*64 +: 64] = p_data;
                m_mask[p_flow][p_word] = 1'b1;
                if (m_mask[p_flow] == 8'hff) begin
                    commit = 1'b1;
                    e.flow = 2'(p_flow);
                    e.line = m_stage[p_flow];
                    e.t = edge_n;
                    m_mask[p_flow] = '0;
                end
            end
            if (pop) void'(q.pop_front());
            if (commit) begin
                if (!was_full || pop) q.push_back(e);
                else if (m_drop != 32'hffff_ffff) m_drop = m_drop + 32'd1;
            end
            p_v = 1'b0;
            if (start && mmio_wr_valid) begin
                off = int'(mmio_wr_addr) - int'(tx_base_addr);
                if (off >= 0 && off < int'(number_of_flows) * 16) begin
                    if (off % 2 != 0) m_err = 1'b1;
                    else begin
                        p_v = 1'b1;
                        p_flow = off / 16;
                        p_word = (off % 16) / 2;
                        p_data = mmio_wr_data;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit   mv;
        seen_t s;
        if (chk_en) begin
            mv = q.size() > 0 && q[0].t + 1 <= edge_n;
            chk("valid", 512'(rpc_out_valid), 512'(mv));
            chk("occupancy", 512'(fifo_occupancy), 512'(q.size()));
            chk("pdrop_count", 512'(pdrop_count), 512'(m_drop));
            chk("error", 512'(error), 512'(m_err));
            if (mv) begin
                chk("flow_id", 512'(rpc_flow_id_out), 512'(q[0].flow));
                chk("line", rpc_out, q[0].line);
            end
            if (rpc_out_valid && rpc_out_ready) begin
                s.flow = int'(rpc_flow_id_out);
                s.w0 = rpc_out[63:0];
                seen.push_back(s);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        mmio_wr_valid = 1'b1;
        mmio_wr_addr = a;
        mmio_wr_data = d;
        @(posedge clk);
        #1;
        mmio_wr_valid = 1'b0;
    endtask

    task automatic line_wr(input logic [15:0] win, input int first, input int last, input int tag);
        for (int k = first; k <= last; k++) wr(win + 16'(2*k), 64'(tag*256 + k));
    endtask

    initial begin
        logic [511:0] exp_line;
        int n0;
        reset = 1'b1; start = 1'b0; number_of_flows = 3'd4; tx_base_addr = 16'h100;
        mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_data = '0; rpc_out_ready = 1'b0;
        idle(3);
        chk_en = 1'b1;
        chk("reset_valid", 512'(rpc_out_valid), 512'(0));
        chk("reset_occ", 512'(fifo_occupancy), 512'(0));
        chk("reset_drop", 512'(pdrop_count), 512'(0));
        chk("reset_err", 512'(error), 512'(0));
        chk("reset_out", rpc_out, 512'(0));
        chk("reset_flow", 512'(rpc_flow_id_out), 512'(0));
        reset = 1'b0; start = 1'b1; rpc_out_ready = 1'b1;
        idle(2);

        // single line on flow 2, latency
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            wr(16'h120 + 16'(2*k), 64'(k));
            exp_line[64*k +: 64] = 64'(k);
        end
        idle(1);
        chk("t1_valid_early", 512'(rpc_out_valid), 512'(0));
        idle(1);
        chk("t1_valid_on_time", 512'(rpc_out_valid), 512'(1));
        chk("t1_flow", 512'(rpc_flow_id_out), 512'(2));
        chk("t1_line", rpc_out, exp_line);
        idle(3);

        // interleaved flows, flow 1 finishes first
        n0 = seen.size();
        for (int k = 0; k < 8; k++) begin
            wr(16'h110 + 16'(2*k), 64'(100 + k));
            if (k < 7) wr(16'h100 + 16'(2*k), 64'(200 + k));
        end
        wr(16'h10E, 64'd207);
        idle(6);
        chk("t2_count", 512'(seen.size() - n0), 512'(2));
        chk("t2_first_flow", 512'(seen[n0].flow), 512'(1));
        chk("t2_first_w0", 512'(seen[n0].w0), 512'(100));
        chk("t2_second_flow", 512'(seen[n0+1].flow), 512'(0));
        chk("t2_second_w0", 512'(seen[n0+1].w0), 512'(200));

        // range and alignment
        n0 = seen.size();
        wr(16'h0FE, 64'd1);
        wr(16'h140, 64'd2);
        idle(4);
        chk("t3_err_clear", 512'(error), 512'(0));
        chk("t3_no_output", 512'(seen.size() - n0), 512'(0));
        wr(16'h101, 64'd3);
        idle(2);
        chk("t3_err_set", 512'(error), 512'(1));

        // full FIFO drops the third line
        rpc_out_ready = 1'b0;
        for (int j = 0; j < 3; j++) line_wr(16'h100, 0, 7, j);
        idle(4);
        chk("t4_occ_full", 512'(fifo_occupancy), 512'(2));
        chk("t4_drop", 512'(pdrop_count), 512'(1));
        n0 = seen.size();
        rpc_out_ready = 1'b1;
        idle(2);
        rpc_out_ready = 1'b0;
        idle(2);
        chk("t4_occ_empty", 512'(fifo_occupancy), 512'(0));
        chk("t4_first_w0", 512'(seen[n0].w0), 512'(0));
        chk("t4_second_w0", 512'(seen[n0+1].w0), 512'(256));

        // commit on the same edge as a pop while full
        line_wr(16'h100, 0, 7, 3);
        line_wr(16'h100, 0, 7, 4);
        line_wr(16'h100, 0, 6, 5);
        idle(3);
        wr(16'h10E, 64'(5*256 + 7));
        rpc_out_ready = 1'b1;
        idle(1);
        rpc_out_ready = 1'b0;
        idle(2);
        chk("t5_occ", 512'(fifo_occupancy), 512'(2));
        chk("t5_drop", 512'(pdrop_count), 512'(1));
        rpc_out_ready = 1'b1;
        idle(4);

        // start deassertion flushes the partial line
        n0 = seen.size();
        line_wr(16'h130, 0, 5, 6);
        idle(2);
        start = 1'b0;
        idle(1);
        start = 1'b1;
        line_wr(16'h130, 0, 7, 7);
        idle(6);
        chk("t6_one_output", 512'(seen.size() - n0), 512'(1));

        // reset mid-assembly discards the partial line
        line_wr(16'h130, 0, 5, 8);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("t6_rst_valid", 512'(rpc_out_valid), 512'(0));
        chk("t6_rst_occ", 512'(fifo_occupancy), 512'(0));
        chk("t6_rst_drop", 512'(pdrop_count), 512'(0));
        chk("t6_rst_err", 512'(error), 512'(0));
        n0 = seen.size();
        line_wr(16'h130, 6, 7, 8);
        idle(5);
        chk("t6_rst_no_output", 512'(seen.size() - n0), 512'(0));

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rpc_out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            start = ($urandom_range(511) != 0);
            if ($urandom_range(99) == 0) number_of_flows = 3'($urandom_range(4, 1));
            mmio_wr_valid = ($urandom_range(3) != 0);
            if ($urandom_range(9) != 0)
                mmio_wr_addr = 16'h100 + 16'($urandom_range(3) * 16 + $urandom_range(7) * 2);
            else
                mmio_wr_addr = 16'($urandom_range(16'h150, 16'h0F0));
            mmio_wr_data = {$urandom, $urandom};
            idle(1);
        end
        mmio_wr_valid = 1'b0; start = 1'b1; rpc_out_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
